// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the sequential controller: instruction codes,
// status codes, the stage-state enum and the memory-access predicate.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_e;

    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Value updates one edge after en; holds at all-ones, never wraps.
module y86_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/y86_seq_controller.sv
// Per-instruction stage sequencer for the sequential Y86 datapath; owns PC and stat.
// 6 cycles per non-memory instruction; MEMORY stalls on mem_ack up to MEM_TIMEOUT cycles.
module y86_seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             hlt,
    input  logic             dmem_error,
    input  logic             mem_ack,
    input  logic [63:0]      updated_pc,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pcup_en,
    output logic             cc_we,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_e        state;
    logic [3:0]    icode_q;
    logic          step_armed;
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            stat       <= STAT_AOK;
            icode_q    <= I_NOP;
            step_armed <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end else if (step) begin
                        state      <= S_FETCH;
                        step_armed <= 1'b1;
                    end
                end
                S_FETCH: begin
                    icode_q <= icode;
                    if (imem_error) begin
                        stat  <= STAT_ADR;
                        state <= S_HALT;
                    end else if (!instr_valid) begin
                        stat  <= STAT_INS;
                        state <= S_HALT;
                    end else if (hlt) begin
                        stat  <= STAT_HLT;
                        state <= S_HALT;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    wait_cnt <= '0;
                    state    <= S_MEMORY;
                end
                S_MEMORY: begin
                    // An ack on the final wait cycle wins over the timeout.
                    if (!is_mem_icode(icode_q)) begin
                        state <= S_WRITEBACK;
                    end else if (mem_ack) begin
                        if (dmem_error) begin
                            stat  <= STAT_ADR;
                            state <= S_HALT;
                        end else begin
                            state <= S_WRITEBACK;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        stat  <= STAT_ADR;
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITEBACK: state <= S_PCUPD;
                S_PCUPD: begin
                    pc         <= updated_pc;
                    step_armed <= 1'b0;
                    state      <= (run && !step_armed) ? S_FETCH : S_IDLE;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs depend only on registered state, so they are glitch-free per cycle.
    assign fetch_en   = (state == S_FETCH);
    assign decode_en  = (state == S_DECODE);
    assign execute_en = (state == S_EXECUTE);
    assign mem_en     = (state == S_MEMORY);
    assign wb_en      = (state == S_WRITEBACK);
    assign pcup_en    = (state == S_PCUPD);
    assign cc_we      = execute_en && (icode_q == I_OPQ);
    assign mem_req    = mem_en && is_mem_icode(icode_q);
    assign busy       = (state != S_IDLE) && (state != S_HALT);
    assign retire     = pcup_en;

    y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (busy),
        .cnt   (cycle_cnt)
    );

    y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (retire),
        .cnt   (instr_cnt)
    );

endmodule
